// File: rtl/rtc_local_addr_sequencer.sv
// Sweeps the 10-entry local RTC shadow memory and issues one RTC bus transaction per entry.
// Optional BCD validation of write data is enabled by defining RTC_SEQ_BCD_CHECK_EN.
module rtc_local_addr_sequencer #(
  parameter int N_REGS      = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wr_mode,
  output logic [3:0] addr_mem_local,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [7:0] addr_rtc,
  output logic       rtc_req,
  output logic       rtc_wr,
  output logic [7:0] rtc_wdata,
  input  logic       rtc_ack,
  input  logic [7:0] rtc_rdata,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_FETCH,
    S_REQ,
    S_STORE,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_REGS - 1);
  localparam logic [7:0] TCNT_MAX = 8'(TIMEOUT_CYC);

  state_t     state;
  logic [3:0] idx;
  logic       mode;
  logic [7:0] tcnt;
  logic       bcd_bad;

  function automatic logic [7:0] map_addr(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h27;
      4'd7:    return 8'h41;
      4'd8:    return 8'h42;
      4'd9:    return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

`ifdef RTC_SEQ_BCD_CHECK_EN
  assign bcd_bad = mode && ((mem_rd_data[7:4] > 4'd9) || (mem_rd_data[3:0] > 4'd9));
`else
  assign bcd_bad = 1'b0;
`endif

  // Addresses are loaded on the edge entering ADDR so the memory read is
  // already in flight during ADDR and its data can be captured in FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      idx            <= 4'd0;
      mode           <= 1'b0;
      tcnt           <= 8'd0;
      addr_mem_local <= 4'hF;
      addr_rtc       <= 8'h00;
      mem_wr_en      <= 1'b0;
      mem_wr_data    <= 8'h00;
      rtc_req        <= 1'b0;
      rtc_wr         <= 1'b0;
      rtc_wdata      <= 8'h00;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done      <= 1'b0;
      mem_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode           <= wr_mode;
            idx            <= 4'd0;
            error          <= 1'b0;
            busy           <= 1'b1;
            addr_mem_local <= 4'd0;
            addr_rtc       <= map_addr(4'd0);
            state          <= S_ADDR;
          end
        end
        S_ADDR: state <= S_FETCH;
        S_FETCH: begin
          if (bcd_bad) begin
            error          <= 1'b1;
            done           <= 1'b1;
            busy           <= 1'b0;
            addr_mem_local <= 4'hF;
            addr_rtc       <= 8'h00;
            state          <= S_FINISH;
          end else begin
            if (mode) rtc_wdata <= mem_rd_data;
            rtc_req <= 1'b1;
            rtc_wr  <= mode;
            tcnt    <= 8'd1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          // ack is tested first so it wins over a simultaneous timeout
          if (rtc_ack) begin
            rtc_req <= 1'b0;
            rtc_wr  <= 1'b0;
            if (mode) begin
              state <= S_NEXT;
            end else begin
              mem_wr_data <= rtc_rdata;
              mem_wr_en   <= 1'b1;
              state       <= S_STORE;
            end
          end else if (tcnt == TCNT_MAX) begin
            rtc_req        <= 1'b0;
            rtc_wr         <= 1'b0;
            error          <= 1'b1;
            done           <= 1'b1;
            busy           <= 1'b0;
            addr_mem_local <= 4'hF;
            addr_rtc       <= 8'h00;
            state          <= S_FINISH;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_STORE: state <= S_NEXT;
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            done           <= 1'b1;
            busy           <= 1'b0;
            addr_mem_local <= 4'hF;
            addr_rtc       <= 8'h00;
            state          <= S_FINISH;
          end else begin
            idx            <= idx + 4'd1;
            addr_mem_local <= idx + 4'd1;
            addr_rtc       <= map_addr(idx + 4'd1);
            state          <= S_ADDR;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_local_addr_sequencer.sv
// Directed bench for rtc_local_addr_sequencer: memory + RTC bus responder models and a
// per-cycle checker driven by an entry-count model of the sweep.
module tb_rtc_local_addr_sequencer;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       wr_mode = 1'b0;
  logic [3:0] addr_mem_local;
  logic [7:0] mem_rd_data = 8'h00;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] addr_rtc;
  logic       rtc_req;
  logic       rtc_wr;
  logic [7:0] rtc_wdata;
  logic       rtc_ack = 1'b0;
  logic [7:0] rtc_rdata = 8'h00;
  logic       busy;
  logic       done;
  logic       error;

  rtc_local_addr_sequencer #(.N_REGS(10), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_mode(wr_mode),
    .addr_mem_local(addr_mem_local), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .addr_rtc(addr_rtc),
    .rtc_req(rtc_req), .rtc_wr(rtc_wr), .rtc_wdata(rtc_wdata),
    .rtc_ack(rtc_ack), .rtc_rdata(rtc_rdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  logic [7:0] mem [16];
  int m_cnt = 0, m_exp_cnt = 0, done_cnt = 0;
  int ack_delay = 3, block_idx = 99, rcnt = 0, req_run = 0, last_run = 0;
  bit m_wr = 0, m_exp_err = 0, no_done = 0;
  logic [7:0] aq [$];
  logic [7:0] wq [$];

  function automatic logic [7:0] exp_addr(input int i);
    return (i < 7) ? 8'(8'h21 + i) : 8'(8'h41 + i - 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checker, memory model and RTC responder, all evaluated on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rtc_req) req_run++;
    else begin
      if (req_run > 0) last_run = req_run;
      req_run = 0;
    end
    if (!busy) begin
      chk("idle_addr_local", addr_mem_local, 4'hF);
      chk("idle_addr_rtc", addr_rtc, 8'h00);
      chk("idle_req", rtc_req, 1'b0);
      chk("idle_wen", mem_wr_en, 1'b0);
    end else begin
      chk("busy_error", error, 1'b0);
    end
    if (rtc_req) begin
      chk("req_idx", addr_mem_local, m_cnt);
      chk("req_addr", addr_rtc, exp_addr(m_cnt));
      chk("req_wr", rtc_wr, m_wr);
      if (m_wr) chk("req_wdata", rtc_wdata, mem[m_cnt]);
    end
    if (mem_wr_en) begin
      chk("store_in_write_mode", m_wr, 1'b0);
      chk("store_idx", addr_mem_local, m_cnt - 1);
      chk("store_data", mem_wr_data, m_cnt - 1 + 16);
      mem[addr_mem_local] = mem_wr_data;
    end
    if (done) begin
      done_cnt++;
      if (no_done) chk("unexpected_done", done, 1'b0);
      else begin
        chk("done_entries", m_cnt, m_exp_cnt);
        chk("done_error", error, m_exp_err);
      end
    end
    mem_rd_data = mem[addr_mem_local];
    rtc_ack = 1'b0;
    if (rtc_req) begin
      rcnt++;
      if (rcnt >= ack_delay && m_cnt != block_idx) begin
        rtc_ack   = 1'b1;
        rtc_rdata = 8'(m_cnt + 16);
        aq.push_back(addr_rtc);
        wq.push_back(rtc_wdata);
        m_cnt++;
        rcnt = 0;
      end
    end else begin
      rcnt = 0;
    end
  end

  task automatic begin_sweep(input bit wr, input int exp_cnt, input bit exp_err);
    @(posedge clk); #1;
    m_wr = wr; m_cnt = 0; m_exp_cnt = exp_cnt; m_exp_err = exp_err; done_cnt = 0;
    aq.delete(); wq.delete();
    wr_mode = wr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input bit wr, input int exp_cnt, input bit exp_err, input int inj);
    bit injd = 0;
    begin_sweep(wr, exp_cnt, exp_err);
    for (int c = 0; c < 6000 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inj >= 0 && !injd && busy && m_cnt == inj) begin
        start = 1'b1; wr_mode = !m_wr; injd = 1;
      end
    end
    repeat (6) begin @(posedge clk); #1; start = 1'b0; end
    wr_mode = wr;
    chk("done_count", done_cnt, 1);
    chk("final_entries", m_cnt, exp_cnt);
    chk("final_error", error, exp_err);
  endtask

  initial begin
    bit reached = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr_local", addr_mem_local, 4'hF);
    chk("rst_addr_rtc", addr_rtc, 8'h00);
    chk("rst_req", rtc_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    reset = 1'b1;

    // 1: read sweep
    run_sweep(1'b0, 10, 1'b0, -1);
    chk("t1_n", aq.size(), 10);
    chk("t1_a0", aq[0], 8'h21);
    chk("t1_a6", aq[6], 8'h27);
    chk("t1_a7", aq[7], 8'h41);
    chk("t1_a9", aq[9], 8'h43);
    chk("t1_mem0", mem[0], 8'h10);
    chk("t1_mem9", mem[9], 8'h19);

    // 2: write sweep
    for (int i = 0; i < 10; i++) mem[i] = 8'(i);
    run_sweep(1'b1, 10, 1'b0, -1);
    chk("t2_a9", aq[9], 8'h43);
    chk("t2_w0", wq[0], 8'h00);
    chk("t2_w4", wq[4], 8'h04);
    chk("t2_w9", wq[9], 8'h09);

    // 3: timeout at index 4, then error cleared by next sweep
    block_idx = 4;
    run_sweep(1'b0, 4, 1'b1, -1);
    chk("t3_req_cycles", last_run, TO);
    chk("t3_error", error, 1'b1);
    chk("t3_addr_local", addr_mem_local, 4'hF);
    block_idx = 99;
    run_sweep(1'b0, 10, 1'b0, -1);
    chk("t3_error_cleared", error, 1'b0);

    // 4: start pulse during busy at index 2
    run_sweep(1'b0, 10, 1'b0, 2);
    chk("t4_n", aq.size(), 10);

    // 5: reset mid-REQ at index 7
    block_idx = 7;
    begin_sweep(1'b0, 10, 1'b0);
    for (int c = 0; c < 3000 && !reached; c++) begin
      @(posedge clk); #1;
      if (rtc_req && m_cnt == 7) reached = 1;
    end
    chk("t5_reached_idx7", reached, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    no_done = 1;
    reset = 1'b0;
    #1;
    chk("t5_req", rtc_req, 1'b0);
    chk("t5_addr_local", addr_mem_local, 4'hF);
    chk("t5_addr_rtc", addr_rtc, 8'h00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_wr", rtc_wr, 1'b0);
    chk("t5_wen", mem_wr_en, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    block_idx = 99;
    repeat (3) @(posedge clk);
    no_done = 0;
    run_sweep(1'b0, 10, 1'b0, -1);
    chk("t5_a0", aq[0], 8'h21);

    // 6: non-BCD byte at index 3 in write mode
    for (int i = 0; i < 10; i++) mem[i] = 8'(i);
    mem[3] = 8'h1A;
`ifdef RTC_SEQ_BCD_CHECK_EN
    run_sweep(1'b1, 3, 1'b1, -1);
    chk("t6_n", aq.size(), 3);
    chk("t6_a2", aq[2], 8'h23);
`else
    run_sweep(1'b1, 10, 1'b0, -1);
    chk("t6_a3", aq[3], 8'h24);
    chk("t6_w3", wq[3], 8'h1A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
